// File: rtl/isp_pkg.sv
// isp_pkg: shared constants, types and helpers for the ISP pixel stages.
// Holds frame defaults, Sobel magnitude width and the Sobel FSM states.
package isp_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int PIPE_LAT       = 3;
  localparam int MAG_W          = 11;

  typedef enum logic [1:0] {
    WAIT_VS,
    IDLE,
    ACTIVE
  } sobel_state_t;

  function automatic logic [15:0] grey8_to_rgb565(input logic [7:0] m);
    return {m[7:3], m[7:2], m[7:3]};
  endfunction

endpackage

// File: rtl/isp_line_buffer.sv
// isp_line_buffer: single-clock line RAM, synchronous read-before-write.
// A read and a write to the same address return the old word.
module isp_line_buffer
  import isp_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // registered read of the old word, then optional write
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (we) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/isp_sobel_edge.sv
// isp_sobel_edge: 3x3 Sobel edge magnitude on the grey raster stream.
// Define ISP_SOBEL_BINARY_EN for thresholded black/white output.
module isp_sobel_edge
  import isp_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
`ifdef ISP_SOBEL_BINARY_EN
  ,
  parameter int THRESH     = 64
`endif
) (
  input  logic        clk_rd,
  input  logic        rst,
  input  logic        in_H_SYNC,
  input  logic        in_V_SYNC,
  input  logic        in_BLANK,
  input  logic [7:0]  in_grey,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        BLANK,
  output logic [15:0] display_data,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int AW = $clog2(IMG_WIDTH);

  sobel_state_t state, state_nx;

  // col == IMG_WIDTH marks pixels past the end of the line
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr, addr1;
  logic [2:0] hs_d, vs_d, bl_d;
  logic run, pix, fall, ok;
  logic [7:0] grey1, tap0, tap1;
  logic pix1, ok1, ok2;
  logic [1:0][7:0] wt, wm, wb;
  logic signed [MAG_W-1:0] gx_c, gy_c, gx, gy;
  logic [MAG_W-1:0] ax, ay, mag;
  logic [7:0] sat;
  logic [15:0] pix_out;

  function automatic logic signed [MAG_W-1:0] ext(input logic [7:0] v);
    return $signed({{(MAG_W - 8){1'b0}}, v});
  endfunction

  assign run  = (state == ACTIVE) && in_V_SYNC;
  assign pix  = run && in_BLANK && (col < CW'(IMG_WIDTH));
  assign fall = bl_d[0] && !in_BLANK;
  assign ok   = pix && (row >= RW'(2)) && (col >= CW'(2));
  assign addr = col[AW-1:0];

  assign H_SYNC = hs_d[2];
  assign V_SYNC = vs_d[2];
  assign BLANK  = bl_d[2];

  // frame state register
  always_ff @(posedge clk_rd) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_nx;
  end

  // frame tracking: a reset mid-frame waits for the next vsync low
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_VS: if (!in_V_SYNC) state_nx = IDLE;
      IDLE:    if (in_V_SYNC)  state_nx = ACTIVE;
      ACTIVE:  if (!in_V_SYNC) state_nx = IDLE;
      default: state_nx = WAIT_VS;
    endcase
  end

  // timing pass-through delay lines
  always_ff @(posedge clk_rd) begin
    if (rst) begin
      hs_d <= '0;
      vs_d <= '0;
      bl_d <= '0;
    end else begin
      hs_d <= {hs_d[1:0], in_H_SYNC};
      vs_d <= {vs_d[1:0], in_V_SYNC};
      bl_d <= {bl_d[1:0], in_BLANK};
    end
  end

  // pixel position; a vsync drop also discards a coincident row step
  always_ff @(posedge clk_rd) begin
    if (rst || !run) begin
      col <= '0;
      row <= '0;
    end else if (fall) begin
      col <= '0;
      if (row != RW'(IMG_HEIGHT - 1)) row <= row + 1'b1;
    end else if (pix) begin
      col <= col + 1'b1;
    end
  end

  isp_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (8)
  ) u_buf0 (
    .clk     (clk_rd),
    .we      (pix),
    .wr_addr (addr),
    .wr_data (in_grey),
    .rd_addr (addr),
    .rd_data (tap0)
  );

  // buf1 takes the old buf0 word one clock later, once it is read out
  isp_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (8)
  ) u_buf1 (
    .clk     (clk_rd),
    .we      (pix1),
    .wr_addr (addr1),
    .wr_data (tap0),
    .rd_addr (addr),
    .rd_data (tap1)
  );

  // stage 1: align the live pixel with the line-buffer reads
  always_ff @(posedge clk_rd) begin
    if (rst) begin
      grey1 <= '0;
      addr1 <= '0;
      pix1  <= 1'b0;
      ok1   <= 1'b0;
    end else begin
      grey1 <= in_grey;
      addr1 <= addr;
      pix1  <= pix;
      ok1   <= ok;
    end
  end

  // gradients: taps form the right column, shift regs the other two
  always_comb begin
    gx_c = (ext(tap1) + (ext(tap0) <<< 1) + ext(grey1))
         - (ext(wt[0]) + (ext(wm[0]) <<< 1) + ext(wb[0]));
    gy_c = (ext(wb[0]) + (ext(wb[1]) <<< 1) + ext(grey1))
         - (ext(wt[0]) + (ext(wt[1]) <<< 1) + ext(tap1));
  end

  // stage 2: slide the window on real pixels and register gradients
  always_ff @(posedge clk_rd) begin
    if (rst) begin
      wt  <= '0;
      wm  <= '0;
      wb  <= '0;
      gx  <= '0;
      gy  <= '0;
      ok2 <= 1'b0;
    end else begin
      if (pix1) begin
        wt <= {tap1, wt[1]};
        wm <= {tap0, wm[1]};
        wb <= {grey1, wb[1]};
      end
      gx  <= gx_c;
      gy  <= gy_c;
      ok2 <= ok1;
    end
  end

  // magnitude, saturation and output format
  always_comb begin
    ax  = gx[MAG_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[MAG_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    sat = (mag > MAG_W'(255)) ? 8'hFF : mag[7:0];
`ifdef ISP_SOBEL_BINARY_EN
    pix_out = (sat >= 8'(THRESH)) ? 16'hFFFF : 16'h0000;
`else
    pix_out = grey8_to_rgb565(sat);
`endif
  end

  // stage 3: output pixel and end-of-frame pulse
  always_ff @(posedge clk_rd) begin
    if (rst) begin
      display_data <= '0;
      frame_done   <= 1'b0;
    end else begin
      display_data <= ok2 ? pix_out : 16'h0000;
      frame_done   <= vs_d[2] & ~vs_d[1];
    end
  end

endmodule

// File: tb/tb_isp_sobel_edge.sv
// tb_isp_sobel_edge: directed frames against hand-derived Sobel results.
// Small frame size keeps runtime short; same logic as the 640x480 build.
module tb_isp_sobel_edge;
  import isp_pkg::*;

  localparam int W = 24;
  localparam int H = 8;
  localparam int S = 12;

  localparam int P_CONST = 0;
  localparam int P_STEP  = 1;
  localparam int P_RAMP  = 2;

  logic        clk_rd = 1'b0;
  logic        rst;
  logic        in_H_SYNC;
  logic        in_V_SYNC;
  logic        in_BLANK;
  logic [7:0]  in_grey;
  logic        H_SYNC;
  logic        V_SYNC;
  logic        BLANK;
  logic [15:0] display_data;
  logic        frame_done;

  isp_sobel_edge #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_rd       (clk_rd),
    .rst          (rst),
    .in_H_SYNC    (in_H_SYNC),
    .in_V_SYNC    (in_V_SYNC),
    .in_BLANK     (in_BLANK),
    .in_grey      (in_grey),
    .H_SYNC       (H_SYNC),
    .V_SYNC       (V_SYNC),
    .BLANK        (BLANK),
    .display_data (display_data),
    .frame_done   (frame_done)
  );

  always #5 clk_rd = ~clk_rd;

  typedef struct {
    logic        h;
    logic        v;
    logic        b;
    logic [15:0] d;
    bit          cd;
    int          r;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_v = 1'b0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pixel(input int pat, input int c);
    if (pat == P_STEP) return (c < S) ? 8'h00 : 8'hFF;
    if (pat == P_RAMP) return 8'(c);
    return 8'h80;
  endfunction

  function automatic logic [15:0] golden(input int pat, input int r,
                                         input int c);
    if (r < 2 || c < 2 || c >= W) return 16'h0000;
    if (pat == P_STEP)
      return (c == S || c == S + 1) ? 16'hFFFF : 16'h0000;
`ifdef ISP_SOBEL_BINARY_EN
    if (pat == P_RAMP) return 16'h0000;
`else
    if (pat == P_RAMP) return 16'h0841;
`endif
    return 16'h0000;
  endfunction

  task automatic cyc(input logic h, input logic v, input logic b,
                     input logic [7:0] g, input logic [15:0] d,
                     input bit cd, input int r, input int c);
    exp_t e;
    exp_t o;
    in_H_SYNC = h;
    in_V_SYNC = v;
    in_BLANK  = b;
    in_grey   = g;
    e.h = h; e.v = v; e.b = b; e.d = d; e.cd = cd; e.r = r; e.c = c;
    q.push_back(e);
    @(posedge clk_rd);
    #1;
    if (q.size() >= PIPE_LAT) begin
      o = q.pop_front();
      check($sformatf("hsync r%0d c%0d", o.r, o.c), 16'(H_SYNC), 16'(o.h));
      check($sformatf("vsync r%0d c%0d", o.r, o.c), 16'(V_SYNC), 16'(o.v));
      check($sformatf("blank r%0d c%0d", o.r, o.c), 16'(BLANK), 16'(o.b));
      check($sformatf("frame_done r%0d c%0d", o.r, o.c),
            16'(frame_done), 16'(last_v & ~o.v));
      last_v = o.v;
      if (o.cd)
        check($sformatf("data r%0d c%0d", o.r, o.c), display_data, o.d);
    end
  endtask

  task automatic idle(input logic v);
    cyc(1'b0, v, 1'b0, 8'h00, 16'h0000, 1'b1, -1, -1);
  endtask

  task automatic do_reset(input logic v);
    exp_t z;
    rst       = 1'b1;
    in_H_SYNC = 1'b0;
    in_V_SYNC = v;
    in_BLANK  = 1'b0;
    in_grey   = 8'h00;
    repeat (2) @(posedge clk_rd);
    #1;
    rst = 1'b0;
    q.delete();
    last_v = 1'b0;
    z.h = 1'b0; z.v = 1'b0; z.b = 1'b0; z.d = 16'h0000;
    z.cd = 1'b1; z.r = -2; z.c = -2;
    repeat (PIPE_LAT - 1) q.push_back(z);
  endtask

  task automatic frame(input int pat, input int rows, input int rst_row,
                       input int long_row);
    bit sup;
    int len;
    sup = 1'b0;
    repeat (4) idle(1'b0);
    for (int r = 0; r < rows; r++) begin
      if (r == rst_row) begin
        do_reset(1'b1);
        sup = 1'b1;
      end
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, r, -1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, r, -1);
      len = (r == long_row) ? W + 6 : W;
      for (int c = 0; c < len; c++)
        cyc(1'b0, 1'b1, 1'b1, pixel(pat, c),
            sup ? 16'h0000 : golden(pat, r, c), 1'b1, r, c);
    end
    repeat (2) idle(1'b1);
  endtask

  task automatic rand_timing(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          16'h0000, 1'b0, -3, i);
  endtask

  initial begin
    do_reset(1'b0);
    check("rst hsync", 16'(H_SYNC), 16'h0000);
    check("rst vsync", 16'(V_SYNC), 16'h0000);
    check("rst blank", 16'(BLANK), 16'h0000);
    check("rst data", display_data, 16'h0000);
    check("rst frame_done", 16'(frame_done), 16'h0000);

    frame(P_CONST, H, -1, -1);
    frame(P_STEP, H + 1, -1, 3);
    frame(P_RAMP, H, -1, -1);
    frame(P_STEP, H, 4, -1);
    frame(P_STEP, H, -1, -1);
    rand_timing(200);
    repeat (6) idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
